// File: rtl/store_checker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : store_checker_pkg                                       |
// | Purpose  : Shared types and constants for the store checker.       |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package store_checker_pkg;

   // Checker verdict states.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } check_state_t;

   // Native bus width of the MIPS computer.
   localparam int unsigned c_bus_w = 32;

   // One logged store.
   // The field order matches the flat {addr, data, pc} packing used by the log FIFO.
   typedef struct packed {
      logic [c_bus_w-1:0] addr;
      logic [c_bus_w-1:0] data;
      logic [c_bus_w-1:0] pc;
   } store_rec_t;

   // Occupancy counter width.
   // The extra bit lets the counter hold DEPTH itself.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int unsigned c_def_depth = 8;
   localparam int unsigned c_cnt_w     = count_width(c_def_depth);

endpackage
`default_nettype wire

// File: rtl/store_checker_write_log_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : write_log_fifo                                          |
// | Purpose  : Show-ahead store-log FIFO with sticky overflow flag.    |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module write_log_fifo
   import store_checker_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned N     = 32,
   localparam int unsigned c_rec_w = 3 * N,
   localparam int unsigned c_ptr_w = $clog2(DEPTH),
   localparam int unsigned c_cw    = count_width(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [c_rec_w-1:0] push_rec,
   output logic [c_rec_w-1:0] head_rec,
   output logic               valid,
   output logic [c_cw-1:0]    count,
   output logic               full,
   output logic               overflow
);

   logic [c_rec_w-1:0] mem_q [DEPTH];
   logic [c_rec_w-1:0] mem_d [DEPTH];
   logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [c_cw-1:0]    count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [c_rec_w-1:0] head_q, head_d;
   logic               full_w, empty_w, pop_acc_w, push_acc_w;

   // Next-state logic for the FIFO.
   // Full and empty come from the occupancy count.
   // Popping frees a slot, so a push into a full log is accepted in the same cycle.
   always_comb begin
      full_w     = (count_q == c_cw'(DEPTH));
      empty_w    = (count_q == '0);
      pop_acc_w  = pop && !empty_w;
      push_acc_w = push && (!full_w || pop_acc_w);
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      head_d     = head_q;
      if (push_acc_w) begin
         mem_d[wr_ptr_q] = push_rec;
         wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      end
      if (pop_acc_w) begin
         rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      if (push_acc_w && !pop_acc_w) begin
         count_d = count_q + c_cw'(1);
      end else if (!push_acc_w && pop_acc_w) begin
         count_d = count_q - c_cw'(1);
      end
      if (push && !push_acc_w) begin
         overflow_d = 1'b1;
      end
      // The head register only updates while the log is non-empty.
      // When the log drains, the head keeps its last value.
      // A push lands at the head only when it leaves exactly one entry.
      if (count_d != '0) begin
         head_d = (push_acc_w && (wr_ptr_q == rd_ptr_d)) ? push_rec : mem_q[rd_ptr_d];
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         head_q     <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         head_q     <= head_d;
      end
   end

   assign head_rec = head_q;
   assign valid    = (count_q != '0);
   assign count    = count_q;
   assign full     = (count_q == c_cw'(DEPTH));
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : store_checker                                           |
// | Purpose  : Logs MIPS data-memory stores and judges the result      |
// |            store as PASS / FAIL / TIMEOUT.                         |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module store_checker
   import store_checker_pkg::*;
#(
   parameter int unsigned   N        = 32,
   parameter int unsigned   DEPTH    = 8,
   parameter int unsigned   TIMEOUT  = 1024,
   parameter logic [N-1:0]  EXP_ADDR = N'(12),
   parameter logic [N-1:0]  EXP_DATA = N'(32'h0000_0096),
   localparam int unsigned  c_cw     = count_width(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            memwrite,
   input  logic [N-1:0]    dataadr,
   input  logic [N-1:0]    writedata,
   input  logic [N-1:0]    pc,
   input  logic            rd_en,
   output logic            log_valid,
   output logic [N-1:0]    log_addr,
   output logic [N-1:0]    log_data,
   output logic [N-1:0]    log_pc,
   output logic [c_cw-1:0] log_count,
   output logic            overflow,
   output logic [31:0]     cycles,
   output logic            done,
   output logic            pass,
   output logic            fail,
   output logic            timeout
);

   check_state_t state_q, state_d;
   logic [31:0]  cycles_q, cycles_d;
   logic         done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
   logic         addr_hit_w, at_limit_w, log_push_w, log_full_w;
   logic [3*N-1:0] head_rec_w;

   // Verdict FSM and cycle counter.
   // A result-address store takes priority over the timeout in the same cycle.
   always_comb begin
      state_d    = state_q;
      cycles_d   = cycles_q;
      addr_hit_w = memwrite && (dataadr == EXP_ADDR);
      at_limit_w = (cycles_q == 32'(TIMEOUT - 1));
      log_push_w = (state_q == S_RUN) && memwrite;
      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_RUN;
         end
         S_RUN: begin
            if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
            if (addr_hit_w)      state_d = (writedata == EXP_DATA) ? S_PASS : S_FAIL;
            else if (at_limit_w) state_d = S_TIMEOUT;
         end
         S_PASS, S_FAIL, S_TIMEOUT: state_d = state_q;
         default: state_d = S_IDLE;
      endcase
      pass_d    = (state_d == S_PASS);
      fail_d    = (state_d == S_FAIL);
      timeout_d = (state_d == S_TIMEOUT);
      done_d    = pass_d || fail_d || timeout_d;
   end

   // Registered FSM state, counter and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cycles_q  <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cycles_q  <= cycles_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
      end
   end

   write_log_fifo #(
      .DEPTH (DEPTH),
      .N     (N)
   ) u_log (
      .clk      (clk),
      .reset    (reset),
      .push     (log_push_w),
      .pop      (rd_en),
      .push_rec ({dataadr, writedata, pc}),
      .head_rec (head_rec_w),
      .valid    (log_valid),
      .count    (log_count),
      .full     (log_full_w),
      .overflow (overflow)
   );

   assign log_addr = head_rec_w[3*N-1:2*N];
   assign log_data = head_rec_w[2*N-1:N];
   assign log_pc   = head_rec_w[N-1:0];
   assign cycles   = cycles_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;

   // The full flag is kept on the FIFO interface for other users.
   // The checker itself does not need it.
   logic unused_w;
   assign unused_w = log_full_w;

endmodule
`default_nettype wire

// File: tb/tb_store_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_store_checker                                        |
// | Purpose  : Scoreboard bench for store_checker.                     |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_store_checker;
   import store_checker_pkg::*;

   localparam int unsigned N     = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 16;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam int unsigned EADDR = 12;
   localparam int unsigned EDATA = 32'h96;
   localparam int          MAXC  = 20;

   logic          clk = 1'b0;
   logic          reset, enable, memwrite, rd_en;
   logic [N-1:0]  dataadr, writedata, pc;
   logic          log_valid, overflow, done, pass, fail, timeout;
   logic [N-1:0]  log_addr, log_data, log_pc;
   logic [CW-1:0] log_count;
   logic [31:0]   cycles;

   always #5 clk = ~clk;

   store_checker #(
      .N(N), .DEPTH(DEPTH), .TIMEOUT(TMO), .EXP_ADDR(32'd12), .EXP_DATA(32'h96)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .memwrite(memwrite),
      .dataadr(dataadr), .writedata(writedata), .pc(pc), .rd_en(rd_en),
      .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data), .log_pc(log_pc),
      .log_count(log_count), .overflow(overflow), .cycles(cycles),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // kind: 0 = pass, 1 = fail, 2 = timeout
   typedef struct {
      int kind;
      int cyc;
      int cnt;
      bit ovf;
   } verdict_t;

   store_rec_t exp_log[$];
   verdict_t   exp_verdict[$];

   // Per-RUN-cycle stimulus schedule, indexed by RUN cycle number.
   bit          s_we   [1:MAXC];
   bit          s_rd   [1:MAXC];
   logic [31:0] s_addr [1:MAXC];
   logic [31:0] s_data [1:MAXC];
   logic [31:0] s_pc   [1:MAXC];

   // Log monitor: every accepted pop must match the next accepted push.
   // Verdict monitor: checks status when done first rises.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      store_rec_t e;
      verdict_t   v;
      if (rd_en && log_valid) begin
         if (exp_log.size() == 0) begin
            chk("log_unexpected_pop", 64'(log_valid), 64'(0));
         end else begin
            e = exp_log.pop_front();
            chk("log_addr", 64'(log_addr), 64'(e.addr));
            chk("log_data", 64'(log_data), 64'(e.data));
            chk("log_pc",   64'(log_pc),   64'(e.pc));
         end
      end
      if (done && !done_prev) begin
         if (exp_verdict.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            v = exp_verdict.pop_front();
            chk("v_pass",    64'(pass),      64'(v.kind == 0));
            chk("v_fail",    64'(fail),      64'(v.kind == 1));
            chk("v_timeout", 64'(timeout),   64'(v.kind == 2));
            chk("v_cycles",  64'(cycles),    64'(v.cyc));
            chk("v_count",   64'(log_count), 64'(v.cnt));
            chk("v_ovf",     64'(overflow),  64'(v.ovf));
         end
      end
      done_prev = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      memwrite  = 1'b0;
      rd_en     = 1'b0;
      enable    = 1'b0;
      dataadr   = '0;
      writedata = '0;
      pc        = '0;
   endtask

   task automatic clear_sched();
      for (int c = 1; c <= MAXC; c++) begin
         s_we[c]   = 1'b0;
         s_rd[c]   = 1'b0;
         s_addr[c] = 32'd4;
         s_data[c] = 32'(c);
         s_pc[c]   = 32'h0040_0000 + 32'(4 * c);
      end
   endtask

   // Model the schedule as an ideal bounded queue, then drive it into the DUT.
   task automatic run_scenario(input string tag);
      int       sz   = 0;
      bit       ovf  = 1'b0;
      int       kind = 2;
      int       cyc  = TMO;
      verdict_t v;
      for (int c = 1; c <= int'(TMO); c++) begin
         if (s_rd[c] && sz > 0) sz--;
         if (s_we[c]) begin
            if (sz < int'(DEPTH)) begin
               exp_log.push_back('{addr: s_addr[c], data: s_data[c], pc: s_pc[c]});
               sz++;
            end else begin
               ovf = 1'b1;
            end
         end
         if (s_we[c] && s_addr[c] == EADDR) begin
            kind = (s_data[c] == EDATA) ? 0 : 1;
            cyc  = c;
            break;
         end
      end
      v.kind = kind; v.cyc = cyc; v.cnt = sz; v.ovf = ovf;
      exp_verdict.push_back(v);

      drive_idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      // A result store while idle must be ignored.
      memwrite = 1'b1; dataadr = EADDR; writedata = EDATA; pc = 32'h1234;
      tick();
      chk({tag, "_idle_cnt"},  64'(log_count), 64'(0));
      chk({tag, "_idle_done"}, 64'(done),      64'(0));
      memwrite = 1'b0; enable = 1'b1;
      tick();
      // Three cycles past the verdict exercise stickiness and the push block.
      for (int c = 1; c <= cyc + 3; c++) begin
         enable    = 1'($urandom_range(0, 1));
         memwrite  = s_we[c];
         dataadr   = s_addr[c];
         writedata = s_data[c];
         pc        = s_pc[c];
         rd_en     = (c <= cyc) ? s_rd[c] : 1'b0;
         tick();
      end
      drive_idle();
      chk({tag, "_done"},    64'(done),      64'(1));
      chk({tag, "_pass"},    64'(pass),      64'(kind == 0));
      chk({tag, "_fail"},    64'(fail),      64'(kind == 1));
      chk({tag, "_timeout"}, 64'(timeout),   64'(kind == 2));
      chk({tag, "_cycles"},  64'(cycles),    64'(cyc));
      chk({tag, "_count"},   64'(log_count), 64'(sz));
      chk({tag, "_ovf"},     64'(overflow),  64'(ovf));
      // Drain the log, then pop once more while it is empty.
      rd_en = 1'b1;
      for (int i = 0; i < sz + 1; i++) tick();
      rd_en = 1'b0;
      chk({tag, "_drained_valid"}, 64'(log_valid),          64'(0));
      chk({tag, "_drained_count"}, 64'(log_count),          64'(0));
      chk({tag, "_log_leftover"},  64'(exp_log.size()),     64'(0));
      chk({tag, "_verdict_seen"},  64'(exp_verdict.size()), 64'(0));
      exp_log.delete();
      exp_verdict.delete();
   endtask

   task automatic reset_mid_run();
      drive_idle();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_done",  64'(done),      64'(0));
      chk("rst_cnt",   64'(log_count), 64'(0));
      chk("rst_cyc",   64'(cycles),    64'(0));
      chk("rst_valid", 64'(log_valid), 64'(0));
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 5; c++) begin
         memwrite  = (c == 1 || c == 3 || c == 4);
         dataadr   = 32'd4;
         writedata = 32'(c);
         pc        = 32'(c * 4);
         tick();
      end
      chk("mid_cnt", 64'(log_count), 64'(3));
      chk("mid_cyc", 64'(cycles),    64'(5));
      drive_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_cyc",   64'(cycles),    64'(0));
      chk("mr_cnt",   64'(log_count), 64'(0));
      chk("mr_valid", 64'(log_valid), 64'(0));
      chk("mr_flags", 64'({done, pass, fail, timeout, overflow}), 64'(0));
      chk("mr_head",  64'({log_addr, log_data}) | 64'(log_pc), 64'(0));
      memwrite = 1'b1; dataadr = EADDR; writedata = EDATA;
      tick(); tick(); tick();
      chk("idle_pass", 64'(pass),      64'(0));
      chk("idle_cnt",  64'(log_count), 64'(0));
      chk("idle_cyc",  64'(cycles),    64'(0));
      drive_idle();
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;
      reset_mid_run();

      // Result store in the 4th RUN cycle.
      clear_sched();
      s_we[4] = 1'b1; s_addr[4] = EADDR; s_data[4] = EDATA;
      run_scenario("pass4");

      // Wrong data: FAIL must stick through a later correct store.
      clear_sched();
      s_we[2] = 1'b1;
      s_we[3] = 1'b1; s_addr[3] = EADDR; s_data[3] = 32'h95;
      s_we[4] = 1'b1; s_addr[4] = EADDR; s_data[4] = EDATA;
      run_scenario("fail3");

      // Only non-result stores, so the run times out.
      clear_sched();
      s_we[2] = 1'b1;  s_addr[2]  = 32'd8;
      s_we[5] = 1'b1;  s_addr[5]  = 32'd8;
      s_we[9] = 1'b1;  s_addr[9]  = 32'd8;
      s_we[16] = 1'b1; s_addr[16] = 32'd8;
      run_scenario("tmo");

      // Ten stores with no pops: the last two are dropped.
      clear_sched();
      for (int c = 1; c <= 10; c++) s_we[c] = 1'b1;
      run_scenario("ovf");

      // Full log with a push and pop in the same cycle.
      clear_sched();
      for (int c = 1; c <= 8; c++) s_we[c] = 1'b1;
      s_we[9]  = 1'b1; s_rd[9]  = 1'b1; s_data[9] = 32'hAA;
      s_we[10] = 1'b1; s_rd[10] = 1'b1; s_addr[10] = EADDR; s_data[10] = EDATA;
      run_scenario("fullrw");

      // Random schedules.
      for (int t = 0; t < 40; t++) begin
         for (int c = 1; c <= MAXC; c++) begin
            int r;
            s_we[c] = ($urandom_range(0, 2) != 0);
            s_rd[c] = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            if (r == 0)      s_addr[c] = EADDR;
            else if (r < 4)  s_addr[c] = 32'd4;
            else if (r < 7)  s_addr[c] = 32'd8;
            else             s_addr[c] = $urandom & 32'hFFFF_FFFC;
            s_data[c] = ($urandom_range(0, 1) == 1) ? EDATA : $urandom;
            s_pc[c]   = $urandom;
         end
         run_scenario("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
